// File: rtl/hazard_fwd_ctrl.sv
// rtl/hazard_fwd_ctrl.sv - EX operand forwarding select, load-use bubble and DIV occupancy control
// Optional feature macro: HAZARD_PERF_EN (adds lu_stall_cnt / div_stall_cnt stall counters)
module hazard_fwd_ctrl #(
  parameter int REG_AW     = 5,
  parameter int DIV_CYCLES = 8,
  parameter int CNT_W      = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_use_rs,
  input  logic              id_use_rt,
  input  logic              id_is_div,
  input  logic [REG_AW-1:0] ex_wreg,
  input  logic              ex_wen,
  input  logic              ex_is_load,
  input  logic [REG_AW-1:0] mem_wreg,
  input  logic              mem_wen,
  input  logic              mem_stall,
  output logic [1:0]        fwd_a_sel,
  output logic [1:0]        fwd_b_sel,
  output logic              stall_if,
  output logic              stall_id,
  output logic              stall_ex,
  output logic              flush_ex,
  output logic              flush_mem,
  output logic              div_busy
`ifdef HAZARD_PERF_EN
  ,
  output logic [CNT_W-1:0]  lu_stall_cnt,
  output logic [CNT_W-1:0]  div_stall_cnt
`endif
);

  localparam int CW = $clog2(DIV_CYCLES + 1);
  localparam logic IDLE     = 1'b0;
  localparam logic DIV_BUSY = 1'b1;

  logic          state;
  logic [CW-1:0] cnt;
  logic          a_ex, a_mem, b_ex, b_mem;
  logic          in_idle, lu;
  logic [1:0]    nxt_a, nxt_b;

  always_comb begin
    a_ex  = id_use_rs && (id_rs != '0) && ex_wen  && (ex_wreg  == id_rs);
    a_mem = id_use_rs && (id_rs != '0) && mem_wen && (mem_wreg == id_rs);
    b_ex  = id_use_rt && (id_rt != '0) && ex_wen  && (ex_wreg  == id_rt);
    b_mem = id_use_rt && (id_rt != '0) && mem_wen && (mem_wreg == id_rt);
    nxt_a = a_ex ? 2'b01 : (a_mem ? 2'b10 : 2'b00);
    nxt_b = b_ex ? 2'b01 : (b_mem ? 2'b10 : 2'b00);
  end

  assign in_idle = (state == IDLE);
  assign lu      = in_idle && !mem_stall && ex_is_load && (a_ex || b_ex);

  // Reset gates every control so a DIV interrupted by rst leaks no stall.
  always_comb begin
    stall_if  = 1'b0;
    stall_id  = 1'b0;
    stall_ex  = 1'b0;
    flush_ex  = 1'b0;
    flush_mem = 1'b0;
    div_busy  = 1'b0;
    if (!rst) begin
      div_busy = !in_idle;
      if (mem_stall) begin
        stall_if = 1'b1;
        stall_id = 1'b1;
        stall_ex = 1'b1;
      end else if (!in_idle) begin
        stall_if  = 1'b1;
        stall_id  = 1'b1;
        stall_ex  = 1'b1;
        flush_mem = 1'b1;
      end else if (lu) begin
        stall_if = 1'b1;
        stall_id = 1'b1;
        flush_ex = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      fwd_a_sel <= 2'b00;
      fwd_b_sel <= 2'b00;
    end else begin
      if (!stall_ex) begin
        fwd_a_sel <= flush_ex ? 2'b00 : nxt_a;
        fwd_b_sel <= flush_ex ? 2'b00 : nxt_b;
      end
      if (!mem_stall) begin
        if (state == IDLE) begin
          if (id_is_div && !lu) begin
            state <= DIV_BUSY;
            cnt   <= CW'(DIV_CYCLES - 1);
          end
        end else if (cnt == CW'(1)) begin
          state <= IDLE;
          cnt   <= '0;
        end else begin
          cnt <= cnt - CW'(1);
        end
      end
    end
  end

`ifdef HAZARD_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      lu_stall_cnt  <= '0;
      div_stall_cnt <= '0;
    end else if (!mem_stall) begin
      if (lu && (lu_stall_cnt != '1))
        lu_stall_cnt <= lu_stall_cnt + CNT_W'(1);
      if (!in_idle && (div_stall_cnt != '1))
        div_stall_cnt <= div_stall_cnt + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_hazard_fwd_ctrl.sv
// tb/tb_hazard_fwd_ctrl.sv - randomized self-checking bench for hazard_fwd_ctrl against a behavioural model
module tb_hazard_fwd_ctrl;

  localparam int DIVC  = 8;
  localparam int CNT_W = 32;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] id_rs, id_rt, ex_wreg, mem_wreg;
  logic       id_use_rs, id_use_rt, id_is_div, ex_wen, ex_is_load, mem_wen, mem_stall;
  logic [1:0] fwd_a_sel, fwd_b_sel;
  logic       stall_if, stall_id, stall_ex, flush_ex, flush_mem, div_busy;
`ifdef HAZARD_PERF_EN
  logic [CNT_W-1:0] lu_stall_cnt, div_stall_cnt;
`endif

  int errors = 0;
  int checks = 0;

  // Model state: remaining DIV busy cycles, expected sels, expected counters.
  int    m_busy = 0;
  int    m_sel_a = 0, m_sel_b = 0;
  bit    m_valid = 1'b0;
  longint m_lu = 0, m_div = 0;
  longint cmax = (64'd1 << CNT_W) - 1;

  hazard_fwd_ctrl #(.REG_AW(5), .DIV_CYCLES(DIVC), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
    .id_is_div(id_is_div), .ex_wreg(ex_wreg), .ex_wen(ex_wen), .ex_is_load(ex_is_load),
    .mem_wreg(mem_wreg), .mem_wen(mem_wen), .mem_stall(mem_stall),
    .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel),
    .stall_if(stall_if), .stall_id(stall_id), .stall_ex(stall_ex),
    .flush_ex(flush_ex), .flush_mem(flush_mem), .div_busy(div_busy)
`ifdef HAZARD_PERF_EN
    , .lu_stall_cnt(lu_stall_cnt), .div_stall_cnt(div_stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // 1 = forward from the stage just ahead (EX now), 2 = from two ahead (MEM now), 0 = regfile
  function automatic int pick(input logic [4:0] src, input logic use_src);
    if (use_src && src != 0 && ex_wen && ex_wreg == src) return 1;
    if (use_src && src != 0 && mem_wen && mem_wreg == src) return 2;
    return 0;
  endfunction

  task automatic idle_inputs();
    id_rs = 0; id_rt = 0; id_use_rs = 0; id_use_rt = 0; id_is_div = 0;
    ex_wreg = 0; ex_wen = 0; ex_is_load = 0; mem_wreg = 0; mem_wen = 0; mem_stall = 0;
  endtask

  task automatic rnd_inputs();
    id_rs = 5'($urandom_range(0, 3)); id_rt = 5'($urandom_range(0, 3));
    ex_wreg = 5'($urandom_range(0, 3)); mem_wreg = 5'($urandom_range(0, 3));
    id_use_rs = 1'($urandom); id_use_rt = 1'($urandom);
    ex_wen = 1'($urandom); mem_wen = 1'($urandom);
    ex_is_load = ($urandom_range(0, 2) == 0);
    id_is_div = ($urandom_range(0, 9) == 0);
    mem_stall = ($urandom_range(0, 5) == 0);
  endtask

  // Called just after a negedge with inputs applied: compare, step model, advance one clock.
  task automatic cycle();
    int pa, pb;
    bit lu;
    logic [5:0] exp_c, act_c;
    #1;
    pa = pick(id_rs, id_use_rs);
    pb = pick(id_rt, id_use_rt);
    lu = (m_busy == 0) && !mem_stall && ex_is_load && (pa == 1 || pb == 1);
    if (rst)              exp_c = 6'b000000;
    else if (mem_stall)   exp_c = {5'b11100, m_busy > 0};
    else if (m_busy > 0)  exp_c = 6'b111011;
    else                  exp_c = {lu, lu, 1'b0, lu, 1'b0, 1'b0};
    act_c = {stall_if, stall_id, stall_ex, flush_ex, flush_mem, div_busy};
    chk("ctrl{if,id,ex,fex,fmem,busy}", act_c, exp_c);
    if (m_valid) begin
      chk("fwd_a_sel", fwd_a_sel, m_sel_a);
      chk("fwd_b_sel", fwd_b_sel, m_sel_b);
`ifdef HAZARD_PERF_EN
      chk("lu_stall_cnt", lu_stall_cnt, m_lu);
      chk("div_stall_cnt", div_stall_cnt, m_div);
`endif
    end
    if (rst) begin
      m_busy = 0; m_sel_a = 0; m_sel_b = 0; m_valid = 1'b1; m_lu = 0; m_div = 0;
    end else if (!mem_stall) begin
      if (m_busy > 0) begin
        m_busy--;
        if (m_div < cmax) m_div++;
      end else begin
        m_sel_a = lu ? 0 : pa;
        m_sel_b = lu ? 0 : pb;
        if (lu && m_lu < cmax) m_lu++;
        if (id_is_div && !lu) m_busy = DIVC - 1;
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic count_div(input bit pulse, output int n);
    n = 0;
    id_is_div = 1; cycle();
    id_is_div = 0;
    for (int k = 0; k < 30; k++) begin
      mem_stall = pulse && (k >= 3 && k <= 5);
      #1;
      if (div_busy && stall_ex) n++;
      cycle();
    end
    mem_stall = 0;
  endtask

  initial begin
    int n;
    idle_inputs();
    rst = 1;
    @(negedge clk);
    // Reset with random inputs
    rnd_inputs(); cycle();
    rnd_inputs(); cycle();
    rnd_inputs(); #1;
    chk("rst fwd_a_sel", fwd_a_sel, 0);
    chk("rst fwd_b_sel", fwd_b_sel, 0);
    chk("rst stalls", {stall_if, stall_id, stall_ex, flush_ex, flush_mem}, 0);
    chk("rst div_busy", div_busy, 0);
    cycle();
    rst = 0; idle_inputs(); cycle();

    // EX forwarding on both operands
    ex_wen = 1; ex_wreg = 5; id_rs = 5; id_rt = 5; id_use_rs = 1; id_use_rt = 1;
    #1 chk("ex fwd no stall", {stall_if, stall_id, stall_ex, flush_ex}, 0);
    cycle();
    chk("ex fwd a", fwd_a_sel, 1);
    chk("ex fwd b", fwd_b_sel, 1);

    // EX beats MEM; reg 0 never forwards
    idle_inputs(); ex_wen = 1; mem_wen = 1; ex_wreg = 7; mem_wreg = 7; id_rs = 7; id_use_rs = 1;
    cycle();
    chk("ex prio a", fwd_a_sel, 1);
    ex_wreg = 0; mem_wreg = 0; id_rs = 0;
    cycle();
    chk("r0 a", fwd_a_sel, 0);

    // Load-use bubble then MEM forwarding
    idle_inputs(); ex_wen = 1; ex_is_load = 1; ex_wreg = 3; id_rt = 3; id_use_rt = 1;
    #1 chk("lu ctrl", {stall_if, stall_id, stall_ex, flush_ex}, 4'b1101);
    cycle();
    chk("lu b", fwd_b_sel, 0);
    ex_wen = 0; ex_is_load = 0; mem_wen = 1; mem_wreg = 3;
    #1 chk("post lu ctrl", {stall_if, stall_id, flush_ex}, 0);
    cycle();
    chk("mem fwd b", fwd_b_sel, 2);

    // DIV occupancy, plain and with a 3-cycle memory wait
    idle_inputs();
    count_div(1'b0, n); chk("div busy cycles", n, DIVC - 1);
    count_div(1'b1, n); chk("div busy cycles w/ stall", n, DIVC - 1 + 3);

    // Reset in the middle of DIV
    id_is_div = 1; cycle(); id_is_div = 0;
    cycle(); cycle();
    rst = 1; #1;
    chk("rst mid div busy", div_busy, 0);
    chk("rst mid div stalls", {stall_if, stall_id, stall_ex, flush_mem}, 0);
    cycle();
    rst = 0; #1;
    chk("after rst busy", div_busy, 0);
    chk("after rst stalls", {stall_if, stall_id, stall_ex, flush_mem}, 0);
`ifdef HAZARD_PERF_EN
    chk("after rst lu cnt", lu_stall_cnt, 0);
    chk("after rst div cnt", div_stall_cnt, 0);
`endif
    cycle();

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      rnd_inputs();
      rst = ($urandom_range(0, 99) == 0);
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
